mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

- Shares the single-port instruction/data memory (8-bit word address, 32-bit data, synchronous read) between two requesters: the instruction-fetch sequencer and the load/store sequencer.
- Arbitrates, drives `mem_lo`/`mem_in`/`mem_en`, counts the memory read latency, and returns read data with a one-cycle valid pulse.
- Replaces ad-hoc wait counters in the core FSM with a request/grant handshake.

## Interface
- `RD_LAT`, 2, memory read latency in cycles from address registered to `mem_out` valid; legal 1..7
- `clk` in 1: clock, rising edge
- `rst` in 1: asynchronous, active-high reset
- `if_req` in 1: fetch read request, held until `if_gnt`
- `if_addr` in 8: fetch word address
- `if_gnt` out 1: one-cycle grant pulse to fetch
- `if_rvalid` out 1: one-cycle pulse, `rdata` holds fetch result
- `ls_req` in 1: load/store request, held until `ls_gnt`
- `ls_we` in 1: 1 = store, 0 = load
- `ls_addr` in 8: load/store word address
- `ls_wdata` in 32: store data
- `ls_gnt` out 1: one-cycle grant pulse to load/store
- `ls_rvalid` out 1: one-cycle pulse; load data valid on `rdata`, or store acknowledge
- `rdata` out 32: shared read-data register
- `mem_lo` out 8: memory address
- `mem_in` out 32: memory write data
- `mem_en` out 1: memory write enable
- `mem_out` in 32: memory read data
- `busy` out 1: high in every state except IDLE

## Operation
- **States.** IDLE, RD_WAIT, WR.
- **IDLE, no request.** If neither `if_req` nor `ls_req` is sampled high, stay in IDLE.
- **IDLE, request sampled.** Pick a winner (see arbitration) and, on the same edge:
  - register the winner's address into `mem_lo`;
  - pulse the winner's grant;
  - load the owner register.
  - Load or fetch: go to RD_WAIT and clear `cnt`.
  - Store: register `ls_wdata` into `mem_in`, set `mem_en`=1, go to WR.
- **RD_WAIT.**
  - Increment `cnt` on each edge.
  - When `cnt`==`RD_LAT`-1: `rdata`<=`mem_out`, pulse the owner's rvalid, return to IDLE.
- **WR.** Next edge: `mem_en`<=0, pulse `ls_rvalid`, return to IDLE.
- **Arbitration, default fixed priority.** When both requests are high, `ls` wins.
- **Address handling.** No arithmetic on addresses; 8-bit values pass through unchanged. `mem_lo` and `mem_in` hold their last value in IDLE.
- **`rdata` hold.** `rdata` holds its value until the next read completes; a store never changes it.
- **Requests while busy.** Not sampled; a requester keeps `req` high and is considered again on return to IDLE.
- **Request withdrawn.** A request dropped before its grant causes no memory access.
- **`mem_en` rule.** `mem_en` is high only in WR, for exactly one cycle per store.
- **`ls_we` sampling.** `ls_we` is sampled only together with the `ls_req` that is granted.
- **`rst` asserted (including mid-access).** All state returns to reset values immediately and the in-flight access is discarded: no rvalid, and `mem_en` drops without waiting for a clock.

## Timing
- **Reset values:**
  - `if_gnt`, `ls_gnt`, `if_rvalid`, `ls_rvalid`, `mem_en`, `busy` = 0
  - `mem_lo` = 8'd0; `mem_in` = 32'd0; `rdata` = 32'd0
  - state IDLE; `cnt` = 0; round-robin pointer = "last granted fetch"
- **Read.** Request sampled at edge E: grant high in cycle E+1, `mem_lo` valid from E+1, rvalid high in cycle E+`RD_LAT`+1.
- **Store.** Request sampled at edge E: `ls_gnt` and `mem_en` high in cycle E+1, `ls_rvalid` high in cycle E+2.
- **Back-to-back.** In the cycle rvalid is high the block is in IDLE and may sample a new request. Read throughput is therefore one access per `RD_LAT`+1 cycles, and one store per 2 cycles.
- **Pulse widths.** Grant and rvalid are each exactly one cycle wide, and each rvalid corresponds to exactly one prior grant.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin arbitration.
  - On a simultaneous request, the requester not granted last wins.
  - The pointer updates on every grant.
  - After reset `ls` wins the first tie.
- `MEM_ARB_RR_EN` undefined: fixed priority, `ls` over `if`; no pointer register.

## Structure
- **Shared package `tiny_risc_v_pkg`:**
  - state enum (IDLE, RD_WAIT, WR);
  - requester id constants (REQ_IF=0, REQ_LS=1);
  - width constants MEM_AW=8, MEM_DW=32.
- **Sub-module `mem_arb_pick`:** combinational winner select from (`if_req`, `ls_req`, last_owner), containing the round-robin/fixed logic under the macro.
- **Top level:** FSM, latency counter and output registers.

## Test plan
- **Single fetch.** `if_req`=1, `if_addr`=8'h05, memory[5]=32'h00A00093, `RD_LAT`=2 → `if_gnt` in cycle 1, `mem_lo`=5, `if_rvalid` in cycle 3 with `rdata`=32'h00A00093, `ls_rvalid` never high.
- **Single store.** `ls_req`=1, `ls_we`=1, `ls_addr`=8'h20, `ls_wdata`=32'hDEADBEEF → `mem_en` high for exactly one cycle with `mem_lo`=8'h20 and `mem_in`=32'hDEADBEEF, `ls_rvalid` on the next cycle, and a later load of 8'h20 returns 32'hDEADBEEF.
- **Contention.** Both requests held continuously for 4 grants:
  - fixed priority → `ls` granted every time;
  - `MEM_ARB_RR_EN` → grants alternate ls, if, ls, if.
- **Busy hold-off.** `ls_req` asserted while a fetch is in RD_WAIT → no `ls_gnt` until the cycle after `if_rvalid`, and `mem_lo` is unchanged during RD_WAIT.
- **Reset mid-read.** Assert `rst` in the cycle after `if_gnt` → no `if_rvalid`, `busy`=0 and `rdata`=0 immediately; after `rst` deasserts a new `if_req` completes normally.
- **Latency sweep.** `RD_LAT`=1 and `RD_LAT`=7, back-to-back fetches of addresses 0..3 → rvalid spacing of 2 and 8 cycles respectively, and data matches memory contents.

Source files
------------

// File: rtl/tiny_risc_v_pkg.sv
// Shared types and constants for the memory port arbiter: FSM states,
// requester ids and memory bus widths.
package tiny_risc_v_pkg;

  localparam int unsigned MEM_AW = 8;
  localparam int unsigned MEM_DW = 32;

  localparam logic REQ_IF = 1'b0;
  localparam logic REQ_LS = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR      = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select between fetch and load/store requesters.
// Define MEM_ARB_RR_EN for round-robin; default is fixed priority (ls over if).
module mem_arb_pick
  import tiny_risc_v_pkg::*;
(
  input  logic i_if_req,
  input  logic i_ls_req,
  input  logic i_last_owner,
  output logic o_any_c,
  output logic o_winner_c
);

  assign o_any_c = i_if_req | i_ls_req;

`ifdef MEM_ARB_RR_EN
  // On a tie the requester that did not win last time goes first
  always_comb begin
    o_winner_c = REQ_IF;
    if (i_if_req && i_ls_req) begin
      o_winner_c = (i_last_owner == REQ_IF) ? REQ_LS : REQ_IF;
    end else if (i_ls_req) begin
      o_winner_c = REQ_LS;
    end
  end
`else
  logic w_unused_last;
  assign w_unused_last = i_last_owner;

  always_comb begin
    o_winner_c = i_ls_req ? REQ_LS : REQ_IF;
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Request/grant arbiter sharing one synchronous-read memory between fetch and
// load/store. Arbitration policy selected by MEM_ARB_RR_EN (see mem_arb_pick).
module mem_port_arbiter
  import tiny_risc_v_pkg::*;
#(
  parameter int unsigned RD_LAT = 2
)
(
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [MEM_AW-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [MEM_AW-1:0] ls_addr,
  input  logic [MEM_DW-1:0] ls_wdata,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [MEM_DW-1:0] rdata,
  output logic [MEM_AW-1:0] mem_lo,
  output logic [MEM_DW-1:0] mem_in,
  output logic              mem_en,
  input  logic [MEM_DW-1:0] mem_out,
  output logic              busy
);

  localparam int unsigned CNT_W = 3;

  arb_state_e        r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic              r_owner, w_owner_nxt;
  logic [MEM_AW-1:0] w_lo_nxt;
  logic [MEM_DW-1:0] w_in_nxt, w_rdata_nxt;
  logic              w_en_nxt, w_if_gnt_nxt, w_ls_gnt_nxt;
  logic              w_if_rv_nxt, w_ls_rv_nxt;
  logic              w_any, w_winner;

  mem_arb_pick u_pick (
    .i_if_req     (if_req),
    .i_ls_req     (ls_req),
    .i_last_owner (r_owner),
    .o_any_c      (w_any),
    .o_winner_c   (w_winner)
  );

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_owner_nxt  = r_owner;
    w_lo_nxt     = mem_lo;
    w_in_nxt     = mem_in;
    w_rdata_nxt  = rdata;
    w_en_nxt     = 1'b0;
    w_if_gnt_nxt = 1'b0;
    w_ls_gnt_nxt = 1'b0;
    w_if_rv_nxt  = 1'b0;
    w_ls_rv_nxt  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_any) begin
          w_owner_nxt = w_winner;
          if (w_winner == REQ_LS) begin
            w_ls_gnt_nxt = 1'b1;
            w_lo_nxt     = ls_addr;
            if (ls_we) begin
              w_in_nxt    = ls_wdata;
              w_en_nxt    = 1'b1;
              w_state_nxt = WR;
            end else begin
              w_cnt_nxt   = '0;
              w_state_nxt = RD_WAIT;
            end
          end else begin
            w_if_gnt_nxt = 1'b1;
            w_lo_nxt     = if_addr;
            w_cnt_nxt    = '0;
            w_state_nxt  = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
        if (r_cnt == CNT_W'(RD_LAT - 1)) begin
          w_rdata_nxt = mem_out;
          w_if_rv_nxt = (r_owner == REQ_IF);
          w_ls_rv_nxt = (r_owner == REQ_LS);
          w_state_nxt = IDLE;
        end
      end
      WR: begin
        w_ls_rv_nxt = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_owner   <= REQ_IF;
      mem_lo    <= '0;
      mem_in    <= '0;
      mem_en    <= 1'b0;
      rdata     <= '0;
      if_gnt    <= 1'b0;
      ls_gnt    <= 1'b0;
      if_rvalid <= 1'b0;
      ls_rvalid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_owner   <= w_owner_nxt;
      mem_lo    <= w_lo_nxt;
      mem_in    <= w_in_nxt;
      mem_en    <= w_en_nxt;
      rdata     <= w_rdata_nxt;
      if_gnt    <= w_if_gnt_nxt;
      ls_gnt    <= w_ls_gnt_nxt;
      if_rvalid <= w_if_rv_nxt;
      ls_rvalid <= w_ls_rv_nxt;
      busy      <= (w_state_nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed and random transactions on
// an RD_LAT=2 instance, plus latency sweeps on RD_LAT=1 and RD_LAT=7 instances.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
  import tiny_risc_v_pkg::*;

  localparam int unsigned MAIN_LAT = 2;

  logic clk, rst;
  logic if_req, if_gnt, if_rvalid, ls_req, ls_we, ls_gnt, ls_rvalid, mem_en, busy;
  logic [7:0]  if_addr, ls_addr, mem_lo;
  logic [31:0] ls_wdata, rdata, mem_in, mem_out;

  logic [31:0] mem [256];
  logic [31:0] ref_mem [256];
  logic [7:0]  m_p1;
  logic [31:0] exp_rdata;
  bit          last_ls;
  int          total, bad;

  function automatic logic [31:0] init_word(input logic [7:0] a);
    if (a == 8'h05) return 32'h00A00093;
    return {a ^ 8'hC3, ~a, a, a ^ 8'h5A};
  endfunction

  mem_port_arbiter #(.RD_LAT(MAIN_LAT)) u_dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .rdata(rdata),
    .mem_lo(mem_lo), .mem_in(mem_in), .mem_en(mem_en), .mem_out(mem_out), .busy(busy)
  );

  // Memory model: address registered once more inside the memory, write on mem_en
  always @(posedge clk) begin
    if (mem_en) mem[mem_lo] <= mem_in;
    m_p1 <= mem_lo;
  end
  assign mem_out = mem[m_p1];

  // Sweep instances: fetch-only, read-only memory
  logic        s1_if_req, s1_if_gnt, s1_if_rvalid, s1_ls_gnt, s1_ls_rvalid, s1_mem_en, s1_busy;
  logic [7:0]  s1_if_addr, s1_mem_lo;
  logic [31:0] s1_rdata, s1_mem_in, s1_mem_out;
  logic        s7_if_req, s7_if_gnt, s7_if_rvalid, s7_ls_gnt, s7_ls_rvalid, s7_mem_en, s7_busy;
  logic [7:0]  s7_if_addr, s7_mem_lo;
  logic [31:0] s7_rdata, s7_mem_in, s7_mem_out;
  logic [7:0]  s7_p [6];

  mem_port_arbiter #(.RD_LAT(1)) u_s1 (
    .clk(clk), .rst(rst),
    .if_req(s1_if_req), .if_addr(s1_if_addr), .if_gnt(s1_if_gnt), .if_rvalid(s1_if_rvalid),
    .ls_req(1'b0), .ls_we(1'b0), .ls_addr(8'h00), .ls_wdata(32'h0),
    .ls_gnt(s1_ls_gnt), .ls_rvalid(s1_ls_rvalid), .rdata(s1_rdata),
    .mem_lo(s1_mem_lo), .mem_in(s1_mem_in), .mem_en(s1_mem_en), .mem_out(s1_mem_out), .busy(s1_busy)
  );
  assign s1_mem_out = init_word(s1_mem_lo);

  mem_port_arbiter #(.RD_LAT(7)) u_s7 (
    .clk(clk), .rst(rst),
    .if_req(s7_if_req), .if_addr(s7_if_addr), .if_gnt(s7_if_gnt), .if_rvalid(s7_if_rvalid),
    .ls_req(1'b0), .ls_we(1'b0), .ls_addr(8'h00), .ls_wdata(32'h0),
    .ls_gnt(s7_ls_gnt), .ls_rvalid(s7_ls_rvalid), .rdata(s7_rdata),
    .mem_lo(s7_mem_lo), .mem_in(s7_mem_in), .mem_en(s7_mem_en), .mem_out(s7_mem_out), .busy(s7_busy)
  );
  always @(posedge clk) begin
    s7_p[0] <= s7_mem_lo;
    for (int k = 1; k < 6; k++) s7_p[k] <= s7_p[k-1];
  end
  assign s7_mem_out = init_word(s7_p[5]);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // One transaction from an idle arbiter; checks grant, routing, timing and data
  task automatic do_txn(input bit r_if, input bit r_ls, input bit we,
                        input logic [7:0] a_if, input logic [7:0] a_ls, input logic [31:0] wd);
    bit exp_ls, st;
    logic [7:0] a;
    int n;
    if (r_if && r_ls) begin
`ifdef MEM_ARB_RR_EN
      exp_ls = !last_ls;
`else
      exp_ls = 1'b1;
`endif
    end else begin
      exp_ls = r_ls;
    end
    st = exp_ls && we;
    a  = exp_ls ? a_ls : a_if;
    if_req = r_if; if_addr = a_if; ls_req = r_ls; ls_we = we; ls_addr = a_ls; ls_wdata = wd;
    n = 0;
    do begin @(negedge clk); n++; end while (!if_gnt && !ls_gnt && n < 20);
    if_req = 1'b0; ls_req = 1'b0;
    ls_we = 1'($urandom); if_addr = 8'($urandom); ls_addr = 8'($urandom); ls_wdata = $urandom;
    last_ls = exp_ls;
    chk("gnt_lat", n, 1);
    chk("ls_gnt", ls_gnt, exp_ls);
    chk("if_gnt", if_gnt, !exp_ls);
    chk("gnt_cycle_rvalid", if_rvalid | ls_rvalid, 0);
    chk("gnt_mem_lo", mem_lo, a);
    chk("gnt_busy", busy, 1);
    chk("gnt_mem_en", mem_en, st);
    if (st) begin
      chk("wr_mem_in", mem_in, wd);
      ref_mem[a] = wd;
      @(negedge clk);
      chk("wr_mem_en_drop", mem_en, 0);
      chk("wr_ls_rvalid", ls_rvalid, 1);
      chk("wr_if_rvalid", if_rvalid, 0);
      chk("wr_rdata_hold", rdata, exp_rdata);
      chk("wr_gnt_width", ls_gnt | if_gnt, 0);
    end else begin
      for (int k = 1; k <= int'(MAIN_LAT); k++) begin
        @(negedge clk);
        if (k < int'(MAIN_LAT)) chk("rd_wait_rvalid", if_rvalid | ls_rvalid, 0);
        chk("rd_mem_lo_hold", mem_lo, a);
      end
      exp_rdata = ref_mem[a];
      chk("rd_if_rvalid", if_rvalid, !exp_ls);
      chk("rd_ls_rvalid", ls_rvalid, exp_ls);
      chk("rd_data", rdata, exp_rdata);
    end
  endtask

  initial begin
    int r, n1, n7;
    int t1 [4];
    int t7 [4];
    total = 0; bad = 0; last_ls = 1'b0; exp_rdata = 32'h0;
    for (int i = 0; i < 256; i++) begin
      mem[i] = init_word(8'(i));
      ref_mem[i] = init_word(8'(i));
    end
    if_req = 0; if_addr = 0; ls_req = 0; ls_we = 0; ls_addr = 0; ls_wdata = 0;
    s1_if_req = 0; s1_if_addr = 0; s7_if_req = 0; s7_if_addr = 0;
    rst = 1'b0;
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_if_gnt", if_gnt, 0);    chk("rst_ls_gnt", ls_gnt, 0);
    chk("rst_if_rvalid", if_rvalid, 0); chk("rst_ls_rvalid", ls_rvalid, 0);
    chk("rst_mem_en", mem_en, 0);    chk("rst_busy", busy, 0);
    chk("rst_mem_lo", mem_lo, 0);    chk("rst_mem_in", mem_in, 0);
    chk("rst_rdata", rdata, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_no_req", busy | if_gnt | ls_gnt, 0);

    // Single fetch, single store, reload of stored word
    do_txn(1, 0, 0, 8'h05, 8'h00, 32'h0);
    chk("fetch_5_data", rdata, 32'h00A00093);
    do_txn(0, 1, 1, 8'h00, 8'h20, 32'hDEADBEEF);
    do_txn(0, 1, 0, 8'h00, 8'h20, 32'h0);
    chk("reload_20", rdata, 32'hDEADBEEF);

    // Busy hold-off: ls request raised during a fetch
    if_req = 1; if_addr = 8'h40;
    @(negedge clk);
    chk("ho_if_gnt", if_gnt, 1);
    if_req = 0; ls_req = 1; ls_we = 0; ls_addr = 8'h41;
    for (int k = 1; k <= int'(MAIN_LAT); k++) begin
      @(negedge clk);
      chk("ho_no_ls_gnt", ls_gnt, 0);
      chk("ho_mem_lo", mem_lo, 8'h40);
    end
    chk("ho_if_rvalid", if_rvalid, 1);
    chk("ho_rdata", rdata, ref_mem[8'h40]);
    @(negedge clk);
    chk("ho_ls_gnt_after", ls_gnt, 1);
    chk("ho_ls_mem_lo", mem_lo, 8'h41);
    ls_req = 0; last_ls = 1'b1;
    repeat (MAIN_LAT) @(negedge clk);
    chk("ho_ls_rvalid", ls_rvalid, 1);
    exp_rdata = ref_mem[8'h41];
    chk("ho_ls_rdata", rdata, exp_rdata);

    // Withdrawn store request causes no access
    if_req = 1; if_addr = 8'h07;
    @(negedge clk);
    if_req = 0; ls_req = 1; ls_we = 1; ls_addr = 8'h30; ls_wdata = 32'h12345678;
    @(negedge clk);
    ls_req = 0;
    last_ls = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("wd_no_ls_gnt", ls_gnt, 0);
      chk("wd_no_mem_en", mem_en, 0);
    end
    do_txn(0, 1, 0, 8'h00, 8'h30, 32'h0);
    chk("wd_mem_intact", rdata, init_word(8'h30));

    // Reset mid-read
    if_req = 1; if_addr = 8'h06;
    @(negedge clk);
    chk("rr_if_gnt", if_gnt, 1);
    if_req = 0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rr_busy", busy, 0);
    chk("rr_rdata", rdata, 0);
    chk("rr_mem_lo", mem_lo, 0);
    exp_rdata = 32'h0; last_ls = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("rr_no_rvalid", if_rvalid | ls_rvalid, 0);
    end
    rst = 1'b0;

    // Contention right after reset
    for (int i = 0; i < 4; i++) do_txn(1, 1, 0, 8'(8 + i), 8'(16 + i), 32'h0);
    do_txn(1, 0, 0, 8'h05, 8'h00, 32'h0);

    // Reset while a store is in WR drops mem_en at once, no write
    ls_req = 1; ls_we = 1; ls_addr = 8'h33; ls_wdata = 32'hCAFEF00D;
    @(negedge clk);
    chk("rw_mem_en_up", mem_en, 1);
    ls_req = 0;
    rst = 1'b1;
    #1;
    chk("rw_mem_en_async", mem_en, 0);
    exp_rdata = 32'h0; last_ls = 1'b0;
    @(negedge clk);
    chk("rw_no_ack", ls_rvalid, 0);
    rst = 1'b0;
    do_txn(0, 1, 0, 8'h00, 8'h33, 32'h0);
    chk("rw_no_write", rdata, init_word(8'h33));

    // Random mix against the transaction-level model
    for (int t = 0; t < 40; t++) begin
      r = $urandom_range(1, 3);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      do_txn(r[0], r[1], 1'($urandom), 8'($urandom_range(0, 15)), 8'($urandom_range(0, 15)), $urandom);
    end

    // Latency sweep: back-to-back fetches of 0..3 on RD_LAT=1 and RD_LAT=7
    n1 = 0; n7 = 0;
    s1_if_req = 1; s1_if_addr = 0; s7_if_req = 1; s7_if_addr = 0;
    for (int cyc = 0; cyc < 200 && (n1 < 4 || n7 < 4); cyc++) begin
      @(negedge clk);
      if (s1_if_gnt) begin
        if (s1_if_addr == 8'd3) s1_if_req = 0; else s1_if_addr = s1_if_addr + 8'd1;
      end
      if (s7_if_gnt) begin
        if (s7_if_addr == 8'd3) s7_if_req = 0; else s7_if_addr = s7_if_addr + 8'd1;
      end
      if (s1_if_rvalid && n1 < 4) begin
        chk("sw1_data", s1_rdata, init_word(8'(n1)));
        t1[n1] = cyc; n1++;
      end
      if (s7_if_rvalid && n7 < 4) begin
        chk("sw7_data", s7_rdata, init_word(8'(n7)));
        t7[n7] = cyc; n7++;
      end
      if (s1_ls_rvalid || s7_ls_rvalid || s1_mem_en || s7_mem_en) chk("sw_ls_side", 1, 0);
    end
    s1_if_req = 0; s7_if_req = 0;
    chk("sw1_count", n1, 4);
    chk("sw7_count", n7, 4);
    for (int k = 1; k < 4; k++) begin
      if (k < n1) chk("sw1_spacing", t1[k] - t1[k-1], 2);
      if (k < n7) chk("sw7_spacing", t7[k] - t7[k-1], 8);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
